// File: rtl/res_wb_queue_pkg.sv
// Shared result/branch types for the writeback skid queue and its neighbours.
// Also holds the core-level default queue depth.
package res_wb_queue_pkg;

   localparam int unsigned SQN_W                 = 10;
   localparam int unsigned RES_W                 = 32;
   localparam int unsigned TAG_W                 = 7;
   localparam int unsigned RES_WBQ_DEPTH_DEFAULT = 4;

   typedef logic [SQN_W-1:0] SqN;

   typedef struct packed {
      logic [RES_W-1:0] result;
      logic [TAG_W-1:0] tagDst;
      SqN               sqN;
      logic             valid;
   } RES_UOp;

   typedef struct packed {
      logic taken;
      SqN   sqN;
   } BranchProv;

   // Younger-than-branch test; the signed difference absorbs sqN wrap-around.
   function automatic logic is_killed(input SqN x, input BranchProv br);
      return br.taken && ($signed(SqN'(x - br.sqN)) > 0);
   endfunction

endpackage

// File: rtl/res_wb_queue.sv
// Writeback skid queue behind a non-stalling ALU port: in-order drain, branch squash, early stall.
// Optional RES_WBQ_BYPASS_EN: an empty queue forwards a live input straight to the output.
module res_wb_queue
   import res_wb_queue_pkg::*;
#(
   parameter int unsigned DEPTH        = RES_WBQ_DEPTH_DEFAULT,
   parameter int unsigned STALL_MARGIN = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  RES_UOp    IN_uop,
   input  BranchProv IN_branch,
   input  logic      IN_wbReady,
   output RES_UOp    OUT_uop,
   output logic      OUT_stall,
   output logic      OUT_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   RES_UOp           entries_q [DEPTH];
   RES_UOp           entries_d [DEPTH];
   logic [DEPTH-1:0] occ_q, occ_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             stall_q, stall_d;

   RES_UOp head_c;
   logic   head_live_c;
   logic   in_live_c;
   logic   full_c;
   logic   bypass_c;
   logic   deq_c;
   logic   enq_req_c;
   logic   enq_c;

   // Head selection, output mux and next-state computation.
   always_comb begin
      head_c      = entries_q[rd_ptr_q];
      head_live_c = occ_q[rd_ptr_q] && vld_q[rd_ptr_q] && !is_killed(head_c.sqN, IN_branch);
      in_live_c   = IN_uop.valid && !is_killed(IN_uop.sqN, IN_branch);
      full_c      = (count_q == CNT_W'(DEPTH));
`ifdef RES_WBQ_BYPASS_EN
      bypass_c    = in_live_c && (count_q == '0);
`else
      bypass_c    = 1'b0;
`endif

      OUT_uop       = head_c;
      OUT_uop.valid = head_live_c;
      if (bypass_c) begin
         OUT_uop       = IN_uop;
         OUT_uop.valid = 1'b1;
      end

      // Occupied-but-dead heads are dropped without waiting for the grant.
      deq_c     = occ_q[rd_ptr_q] && (!head_live_c || IN_wbReady);
      enq_req_c = in_live_c && !(bypass_c && IN_wbReady);
      enq_c     = enq_req_c && (!full_c || deq_c);

      entries_d = entries_q;
      occ_d     = occ_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         vld_d[i] = vld_q[i] && !is_killed(entries_q[i].sqN, IN_branch);
      end

      if (deq_c) begin
         occ_d[rd_ptr_q] = 1'b0;
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      end
      if (enq_c) begin
         entries_d[wr_ptr_q] = IN_uop;
         occ_d[wr_ptr_q]     = 1'b1;
         vld_d[wr_ptr_q]     = 1'b1;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(enq_c) - CNT_W'(deq_c);
      stall_d = (count_d > CNT_W'(DEPTH - STALL_MARGIN - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q    <= '0;
         vld_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         stall_q  <= 1'b0;
      end else begin
         occ_q    <= occ_d;
         vld_q    <= vld_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         stall_q  <= stall_d;
      end
   end

   // Payload storage needs no reset; occupancy bits qualify it.
   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(enq_req_c && full_c && !deq_c))
            else $error("res_wb_queue: enqueue into full queue, result dropped");
      end
   end

   assign OUT_stall = stall_q;
   assign OUT_empty = (count_q == '0);

endmodule

// File: tb/tb_res_wb_queue.sv
// Self-checking bench for res_wb_queue: directed scenarios plus random traffic vs a queue model.
// Honours RES_WBQ_BYPASS_EN the same way the design does.
module tb_res_wb_queue;
   import res_wb_queue_pkg::*;

   localparam int DEPTH  = 4;
   localparam int MARGIN = 2;

   logic      clk;
   logic      rst;
   RES_UOp    in_uop;
   BranchProv in_branch;
   logic      in_wb_ready;
   RES_UOp    out_uop;
   logic      out_stall;
   logic      out_empty;

   int n_tests;
   int n_failed;
   int seq;

   typedef struct {
      int          sqn;
      logic [31:0] res;
      bit          alive;
   } m_ent_t;

   m_ent_t mq[$];
   bit     m_stall;

   res_wb_queue #(.DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
      .clk        (clk),
      .rst        (rst),
      .IN_uop     (in_uop),
      .IN_branch  (in_branch),
      .IN_wbReady (in_wb_ready),
      .OUT_uop    (out_uop),
      .OUT_stall  (out_stall),
      .OUT_empty  (out_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Younger than branch means the 10-bit forward distance lies in 1..511.
   function automatic bit m_killed(input int x, input bit bt, input int bsq);
      int d;
      d = (x - bsq) & 1023;
      return bt && (d != 0) && (d < 512);
   endfunction

   // One clock: predict, drive, check at negedge, advance the model.
   task automatic cycle(input bit iv, input int isq, input bit bt, input int bsq, input bit rdy);
      bit          exp_v;
      int          exp_sqn;
      logic [31:0] exp_res;
      bit          deq;
      bit          byp_used;
      bit          enq;
      logic [31:0] ires;
      m_ent_t      e;

      ires     = $urandom;
      exp_v    = 1'b0;
      exp_sqn  = 0;
      exp_res  = '0;
      deq      = 1'b0;
      byp_used = 1'b0;

      if (mq.size() > 0) begin
         if (mq[0].alive && !m_killed(mq[0].sqn, bt, bsq)) begin
            exp_v   = 1'b1;
            exp_sqn = mq[0].sqn;
            exp_res = mq[0].res;
            deq     = rdy;
         end else begin
            deq = 1'b1;
         end
      end
`ifdef RES_WBQ_BYPASS_EN
      else if (iv && !m_killed(isq, bt, bsq)) begin
         exp_v    = 1'b1;
         exp_sqn  = isq;
         exp_res  = ires;
         byp_used = rdy;
      end
`endif
      enq = iv && !m_killed(isq, bt, bsq) && !byp_used;
      // Never present an illegal overflow; the issue stage would have been stalled.
      if (enq && mq.size() == DEPTH && !deq) begin
         iv  = 1'b0;
         enq = 1'b0;
      end

      in_uop.valid      = iv;
      in_uop.sqN        = SqN'(isq);
      in_uop.result     = ires;
      in_uop.tagDst     = 7'(isq);
      in_branch.taken   = bt;
      in_branch.sqN     = SqN'(bsq);
      in_wb_ready       = rdy;

      @(negedge clk);
      chk("out_valid", 32'(out_uop.valid), 32'(exp_v));
      if (exp_v) begin
         chk("out_sqn", 32'(out_uop.sqN), 32'(exp_sqn));
         chk("out_res", out_uop.result, exp_res);
      end
      chk("stall", 32'(out_stall), 32'(m_stall));
      chk("empty", 32'(out_empty), 32'(mq.size() == 0));

      if (deq) void'(mq.pop_front());
      foreach (mq[i]) if (m_killed(mq[i].sqn, bt, bsq)) mq[i].alive = 1'b0;
      if (enq) begin
         e.sqn = isq; e.res = ires; e.alive = 1'b1;
         mq.push_back(e);
      end
      m_stall = (mq.size() >= DEPTH - MARGIN);

      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0, rdy);
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      in_uop          = '0;
      in_branch       = '0;
      in_wb_ready     = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      m_stall = 1'b0;
   endtask

   initial begin
      n_tests  = 0;
      n_failed = 0;
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_valid", 32'(out_uop.valid), 32'd0);
      chk("rst_stall", 32'(out_stall), 32'd0);
      chk("rst_empty", 32'(out_empty), 32'd1);
      @(posedge clk);
      #1;

      // 1: grant high, back-to-back stream
      for (int s = 1; s <= 10; s++) cycle(1'b1, s, 1'b0, 0, 1'b1);
      idle(3, 1'b1);

      // 2: grant low, stall rises, fill, then drain
      cycle(1'b1, 1, 1'b0, 0, 1'b0);
      cycle(1'b1, 2, 1'b0, 0, 1'b0);
      idle(1, 1'b0);
      chk("stall_after_2", 32'(out_stall), 32'd1);
      cycle(1'b1, 3, 1'b0, 0, 1'b0);
      cycle(1'b1, 4, 1'b0, 0, 1'b0);
      idle(6, 1'b1);
      chk("drained_empty", 32'(out_empty), 32'd1);

      // 3: squash younger than branch 6
      for (int s = 5; s <= 8; s++) cycle(1'b1, s, 1'b0, 0, 1'b0);
      cycle(1'b0, 0, 1'b1, 6, 1'b0);
      idle(6, 1'b1);

      // 4: wrap-around kill
      cycle(1'b1, 'h3FE, 1'b0, 0, 1'b0);
      cycle(1'b1, 'h3FF, 1'b0, 0, 1'b0);
      cycle(1'b1, 'h000, 1'b0, 0, 1'b0);
      cycle(1'b0, 0, 1'b1, 'h3FF, 1'b0);
      idle(5, 1'b1);

      // 5: enqueue+dequeue on a full queue
      for (int s = 20; s < 24; s++) cycle(1'b1, s, 1'b0, 0, 1'b0);
      for (int s = 24; s < 28; s++) cycle(1'b1, s, 1'b0, 0, 1'b1);
      idle(6, 1'b1);

      // 6: reset with pending entries
      for (int s = 30; s < 33; s++) cycle(1'b1, s, 1'b0, 0, 1'b0);
      do_reset();
      cycle(1'b1, 9, 1'b0, 0, 1'b1);
      idle(3, 1'b1);

      // Random traffic
      seq = 100;
      for (int i = 0; i < 600; i++) begin
         bit iv, bt, rdy;
         int bsq;
         iv  = ($urandom % 4) != 0;
         bt  = ($urandom % 12) == 0;
         bsq = (seq - int'($urandom_range(0, 5))) & 1023;
         rdy = ($urandom % 3) != 0;
         cycle(iv, seq, bt, bsq, rdy);
         if (iv) seq = (seq + 1) & 1023;
      end
      idle(8, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
